mips_cpu_harvard_mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM between the instruction and data ports of mips_cpu_harvard. The block sequences each CPU cycle as an instruction fetch, then an optional data access. It then releases the CPU for exactly one enabled clock by pulsing its clk_enable. It sits between the CPU and a unified memory model; testbenches run the CPU against unified RAM through it.

---
 rtl/mips_cpu_harvard_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mips_cpu_harvard_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_harvard_mem_arbiter.sv
// Time-multiplexes one single-port synchronous RAM between the fetch and data ports of
// mips_cpu_harvard, then releases the CPU for one clk_enable cycle. Optional macro: ARB_STALL_COUNT_EN.
module mips_cpu_harvard_mem_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  output logic        cpu_clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic [31:0] stall_cycles
);

  typedef enum logic [2:0] {
    S_IFETCH,
    S_IWAIT,
    S_DACC,
    S_DWAIT,
    S_RELEASE,
    S_HALT
  } state_e;

  // The wait counter runs 0..READ_LATENCY-1; the last value is the capture cycle.
  localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic        committed_q, committed_d;
  logic [31:0] instr_rdata_q, instr_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IFETCH;
      lat_cnt_q     <= '0;
      committed_q   <= 1'b0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      committed_q   <= committed_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    committed_d    = committed_q;
    instr_rdata_d  = instr_rdata_q;
    data_rdata_d   = data_rdata_q;
    cpu_clk_enable = 1'b0;
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;

    if (reset) begin
      // Let the CPU see its own synchronous reset; the RAM stays idle.
      cpu_clk_enable = 1'b1;
    end else begin
      unique case (state_q)
        S_IFETCH: begin
          if (committed_q && !cpu_active) begin
            state_d = S_HALT;
          end else begin
            mem_address = instr_address;
            mem_read    = 1'b1;
            lat_cnt_d   = '0;
            state_d     = S_IWAIT;
          end
        end
        S_IWAIT: begin
          if (lat_cnt_q == LAST_CNT) begin
            instr_rdata_d = mem_readdata;
            lat_cnt_d     = '0;
            state_d       = S_DACC;
          end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
          end
        end
        S_DACC: begin
          // A store wins over a simultaneous load request.
          if (data_write) begin
            mem_address   = data_address;
            mem_writedata = data_writedata;
            mem_write     = 1'b1;
            state_d       = S_RELEASE;
          end else if (data_read) begin
            mem_address = data_address;
            mem_read    = 1'b1;
            lat_cnt_d   = '0;
            state_d     = S_DWAIT;
          end else begin
            cpu_clk_enable = 1'b1;
            committed_d    = 1'b1;
            state_d        = S_IFETCH;
          end
        end
        S_DWAIT: begin
          if (lat_cnt_q == LAST_CNT) begin
            data_rdata_d = mem_readdata;
            lat_cnt_d    = '0;
            state_d      = S_RELEASE;
          end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
          end
        end
        S_RELEASE: begin
          cpu_clk_enable = 1'b1;
          committed_d    = 1'b1;
          state_d        = S_IFETCH;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IFETCH;
        end
      endcase
    end
  end

  assign instr_readdata = instr_rdata_q;
  assign data_readdata  = data_rdata_q;

`ifdef ARB_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  // Counts every live cycle in which the CPU is held; wraps naturally at 2^32.
  always_comb begin
    stall_d = stall_q;
    if (state_q != S_HALT && !cpu_clk_enable) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mips_cpu_harvard_mem_arbiter.sv
// Randomized bench: the bench plays CPU and unified RAM, and predicts each instruction's
// cycle-by-cycle strobe timeline from the cycles-per-instruction rules.
module tb_mips_cpu_harvard_mem_arbiter;

  localparam int LAT = 3;
`ifdef ARB_STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  localparam int OP_NOP   = 0;
  localparam int OP_LOAD  = 1;
  localparam int OP_STORE = 2;
  localparam int OP_BOTH  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_active;
  logic        cpu_clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic [31:0] stall_cycles;

  mips_cpu_harvard_mem_arbiter #(.READ_LATENCY(LAT)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_active     (cpu_active),
    .cpu_clk_enable (cpu_clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ram     [16];  // device RAM, written by what the DUT actually strobes
  logic [31:0] ref_mem [16];  // reference RAM, written by instruction semantics
  logic [31:0] pipe    [LAT];
  logic [31:0] exp_ird;
  logic [31:0] exp_drd;
  logic [31:0] stall_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM device: apply this cycle's write, then shift the read-latency pipeline.
  task automatic dev_update();
    if (mem_write === 1'b1) ram[mem_address[5:2]] = mem_writedata;
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = (mem_read === 1'b1) ? ram[mem_address[5:2]] : $urandom;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    mem_readdata = pipe[LAT-1];
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic en, input bit count_stall);
    @(negedge clk);
    check("mem_read", 32'(mem_read), 32'(rd));
    check("mem_write", 32'(mem_write), 32'(wr));
    check("mem_address", mem_address, addr);
    check("mem_writedata", mem_writedata, wd);
    check("cpu_clk_enable", 32'(cpu_clk_enable), 32'(en));
    check("instr_readdata", instr_readdata, exp_ird);
    check("data_readdata", data_readdata, exp_drd);
    check("stall_cycles", stall_cycles, STALL_EN ? stall_model : 32'd0);
    if (count_stall) stall_model = stall_model + 32'd1;
    dev_update();
    advance();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_clk_enable", 32'(cpu_clk_enable), 32'd1);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      if (i > 0) begin
        check("rst_instr_readdata", instr_readdata, 32'd0);
        check("rst_data_readdata", data_readdata, 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
      end
      dev_update();
      advance();
    end
    reset       = 1'b0;
    exp_ird     = '0;
    exp_drd     = '0;
    stall_model = '0;
  endtask

  // One CPU instruction: IFETCH at k=0, L wait cycles, data slot at k=L+1, then
  // optional load wait and release. abort_k >= 0 leaves with reset pending for cycle abort_k.
  task automatic run_instr(input int op, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input int abort_k);
    bit          is_wr;
    bit          is_rd;
    int          n;
    logic        rd;
    logic        wr;
    logic        en;
    logic [31:0] addr;
    logic [31:0] wdat;
    is_wr = (op == OP_STORE) || (op == OP_BOTH);
    is_rd = (op == OP_LOAD);
    n = is_wr ? LAT + 3 : (is_rd ? 2 * LAT + 3 : LAT + 2);
    instr_address  = ia;
    data_address   = da;
    data_read      = (op == OP_LOAD) || (op == OP_BOTH);
    data_write     = is_wr;
    data_writedata = wd;
    for (int k = 0; k < n; k++) begin
      if (k == abort_k) return;
      rd = 1'b0; wr = 1'b0; en = 1'b0; addr = '0; wdat = '0;
      if (k == 0) begin
        rd = 1'b1; addr = ia;
      end else if (k == LAT + 1) begin
        exp_ird = ref_mem[ia[5:2]];
        if (is_wr) begin
          wr = 1'b1; addr = da; wdat = wd;
        end else if (is_rd) begin
          rd = 1'b1; addr = da;
        end else begin
          en = 1'b1;
        end
      end else if (k == n - 1) begin
        en = 1'b1;
        if (is_rd) exp_drd = ref_mem[da[5:2]];
      end
      step(rd, wr, addr, wdat, en, !en);
    end
    if (is_wr) ref_mem[da[5:2]] = wd;
  endtask

  // Expects the next IFETCH to enter HALT: nothing but one stalled cycle, then silence.
  task automatic run_halt(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, k == 0);
  endtask

  function automatic logic [31:0] rand_ia();
    return 32'hBFC0_0000 | (32'($urandom_range(0, 15)) << 2);
  endfunction

  function automatic logic [31:0] rand_da();
    return 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    reset          = 1'b1;
    cpu_active     = 1'b1;
    instr_address  = '0;
    data_address   = '0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_writedata = '0;
    mem_readdata   = '0;
    exp_ird        = '0;
    exp_drd        = '0;
    stall_model    = '0;
    for (int i = 0; i < 16; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    ram[0]     = 32'h0000_0000;
    ref_mem[0] = 32'h0000_0000;

    do_reset(3);
    run_instr(OP_NOP, 32'hBFC0_0000, 32'd0, 32'd0, -1);

    ram[0]     = 32'hDEAD_BEEF;
    ref_mem[0] = 32'hDEAD_BEEF;
    run_instr(OP_LOAD, 32'hBFC0_0004, 32'h0000_1000, 32'd0, -1);
    run_instr(OP_STORE, 32'hBFC0_0008, 32'h0000_2004, 32'h1234_5678, -1);
    run_instr(OP_LOAD, 32'hBFC0_000C, 32'h0000_2004, 32'd0, -1);
    run_instr(OP_BOTH, 32'hBFC0_0010, 32'h0000_2008, 32'hCAFE_F00D, -1);
    run_instr(OP_LOAD, 32'hBFC0_0014, 32'h0000_2008, 32'd0, -1);

    for (int i = 0; i < 10; i++) run_instr(OP_NOP, rand_ia(), rand_da(), $urandom, -1);
    for (int i = 0; i < 150; i++) begin
      run_instr($urandom_range(0, 3), rand_ia(), rand_da(), $urandom, -1);
    end

    cpu_active = 1'b0;
    run_halt(6);

    cpu_active = 1'b1;
    do_reset(2);
    run_instr(OP_LOAD, rand_ia(), 32'h0000_1010, 32'd0, -1);
    run_instr(OP_LOAD, rand_ia(), 32'h0000_1014, 32'd0, LAT + 3);
    do_reset(2);
    run_instr(OP_STORE, rand_ia(), 32'h0000_1018, 32'h5555_AAAA, LAT + 1);
    do_reset(2);
    run_instr(OP_LOAD, rand_ia(), 32'h0000_1018, 32'd0, -1);
    for (int i = 0; i < 20; i++) begin
      run_instr($urandom_range(0, 3), rand_ia(), rand_da(), $urandom, -1);
    end

    do_reset(2);
    cpu_active = 1'b0;
    run_instr(OP_NOP, rand_ia(), rand_da(), 32'd0, -1);
    run_halt(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
